mic1_mem_arbiter: RTL and testbench
===================================

# mic1_mem_arbiter

Shares one single-port, synchronous-read word RAM between the mic1 core's data port (MAR/MDR read/write) and its instruction-fetch port (PC/MBR). It issues at most one RAM access per cycle, with data before fetch, and returns read results in holding registers. It asserts `stall` to freeze the core's clock enable until every result the core will sample is stable. It sits between `mic1` and the main-memory RAM macro in the top level.

## Interface
Parameters:
- `ADDR_W`, 16, RAM word-address width.
- `RD_LATENCY`, 1, RAM read latency in cycles from address to `ram_rdata` valid. Legal range is 1..4.

Ports:
- `clk`  in  1  core clock. All state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  32  data word address (MAR).
- `mem_wdata`  in  32  write data (MDR).
- `mem_read`  in  1  data read request.
- `mem_write`  in  1  data write request.
- `mem_fetch`  in  1  instruction byte fetch request.
- `mem_addr_instr`  in  32  fetch byte address (PC).
- `mem_rdata`  out  32  registered data read result.
- `mem_rd_instr`  out  8  registered fetched byte.
- `stall`  out  1  core clock-enable inhibit. The core holds all state while this is 1.
- `protocol_err`  out  1  one-cycle pulse when read and write are requested together.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data.

## Operation
States: IDLE, WAIT_D, ISSUE_F, WAIT_F. A latency counter `cnt` is 3 bits wide.

Address mapping:
- Data access: `ram_addr = mem_addr[ADDR_W-1:0]`. Upper address bits are ignored (aliasing).
- Fetch access: word address is `mem_addr_instr[ADDR_W+1:2]`. The byte lane is `mem_addr_instr[1:0]`, big-endian: lane 0 = `[31:24]`, lane 1 = `[23:16]`, lane 2 = `[15:8]`, lane 3 = `[7:0]`.
- The fetch word address and lane are latched at request capture.

IDLE (`stall`=0):
- RAM signals are driven combinationally from the request.
- Data request present: `ram_en`=1, `ram_we`=`mem_write`, address and write data taken from the data port.
- Otherwise, fetch request present: `ram_en`=1, `ram_we`=0, fetch word address.
- Requests are captured at the clock edge. A fetch that coincides with a data request is latched as pending.
- Next state:
  - Read issued: WAIT_D, `cnt`=`RD_LATENCY`.
  - Write issued with fetch pending: ISSUE_F.
  - Write issued alone: stay in IDLE.
  - Fetch issued alone: WAIT_F, `cnt`=`RD_LATENCY`.
- `mem_read` and `mem_write` both set: the write is performed and the read is dropped. `mem_rdata` is unchanged and `protocol_err`=1 for that cycle.

WAIT_D (`stall`=1):
- `cnt` decrements each cycle.
- On the cycle with `cnt`=1: `mem_rdata` <= `ram_rdata`, then go to ISSUE_F if a fetch is pending, else IDLE.

ISSUE_F (`stall`=1):
- `ram_en`=1, `ram_we`=0, latched fetch word address.
- Next state: WAIT_F, `cnt`=`RD_LATENCY`.

WAIT_F (`stall`=1):
- On the cycle with `cnt`=1: `mem_rd_instr` <= selected lane of `ram_rdata`, then go to IDLE.

General rules:
- Request inputs are ignored whenever `stall`=1.
- Results hold until overwritten by a later read or fetch.

## Timing
- Reset values: state IDLE; `stall`=0; `mem_rdata`=0; `mem_rd_instr`=0; `protocol_err`=0; `cnt`=0; pending cleared.
- While `resetn`=0: `ram_en`=0 and `ram_we`=0, overriding the combinational IDLE drive.
- Reset asserted mid-operation aborts the access and drops any pending fetch. A RAM write already issued is not undone.
- Stall cycles per captured request, with L=`RD_LATENCY`:
  - write only: 0
  - read only: L
  - fetch only: L
  - write+fetch: L+1
  - read+fetch: 2L+1
- Result visibility: results are visible in the first cycle with `stall`=0 after the request. This matches the core's rule that a result is sampled in the cycle after issue.
- Exactly one RAM access per cycle. `ram_we` is high only in an IDLE issue cycle.
- `stall` is a registered state decode. It has no combinational path from the request inputs.

## Test plan
- Read alone, L=1: RAM[0x10]=0xDEADBEEF, `mem_read` with `mem_addr`=0x10 → `stall` high exactly 1 cycle; `mem_rdata`=0xDEADBEEF when `stall` falls.
- Write then read back: write 0x12345678 to 0x20 → 0 stall cycles, `ram_we` pulses once; a following read of 0x20 returns 0x12345678.
- Read+fetch together, L=2: RAM[0x3]=0xA1B2C3D4, RAM[0x4]=0x11223344, `mem_addr`=0x3, `mem_addr_instr`=0x11 → `stall` high 5 cycles, access order data then fetch; `mem_rdata`=0xA1B2C3D4, `mem_rd_instr`=0x22.
- Lane and wrap, ADDR_W=16: `mem_addr_instr`=0xFFFFFFFF, RAM[0xFFFF]=0x000000AB → `mem_rd_instr`=0xAB. `mem_addr`=0x10005 aliases to word 0x5.
- Read and write together: `protocol_err` pulses 1 cycle, the write lands, `mem_rdata` is unchanged, `stall`=0.
- Reset mid-WAIT_F → `stall`=0, outputs zero, state IDLE immediately (asynchronous); the pending fetch is not issued after release.

Source files
------------

// File: rtl/mic1_mem_arbiter.sv
// Arbitrates one single-port synchronous-read RAM between the mic1 data port
// (MAR/MDR) and the instruction-fetch port (PC/MBR), stalling the core until results are stable.
module mic1_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_fetch,
    input  logic [31:0]       mem_addr_instr,
    output logic [31:0]       mem_rdata,
    output logic [7:0]        mem_rd_instr,
    output logic              stall,
    output logic              protocol_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D  = 2'd1,
        ISSUE_F = 2'd2,
        WAIT_F  = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        instr_q, instr_d;

    logic              ram_en_c;
    logic              ram_we_c;
    logic              perr_c;
    logic              data_req;
    logic [ADDR_W-1:0] fetch_word;
    logic [1:0]        fetch_lane;

    // Address bits above the RAM size alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr_instr[31:ADDR_W+2]};

    assign data_req   = mem_read | mem_write;
    assign fetch_word = mem_addr_instr[ADDR_W+1:2];
    assign fetch_lane = mem_addr_instr[1:0];

    // Big-endian byte select: lane 0 is the most significant byte.
    function automatic logic [7:0] sel_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        faddr_d   = faddr_q;
        lane_d    = lane_q;
        rdata_d   = rdata_q;
        instr_d   = instr_q;
        ram_en_c  = 1'b0;
        ram_we_c  = 1'b0;
        perr_c    = 1'b0;
        ram_addr  = mem_addr[ADDR_W-1:0];
        ram_wdata = mem_wdata;

        case (state_q)
            IDLE: begin
                if (data_req) begin
                    ram_en_c = 1'b1;
                    ram_we_c = mem_write;
                    perr_c   = mem_read & mem_write;
                    if (mem_fetch) begin
                        pend_d  = 1'b1;
                        faddr_d = fetch_word;
                        lane_d  = fetch_lane;
                    end
                    // A write wins over a simultaneous read; the read is dropped.
                    if (mem_write) begin
                        if (mem_fetch) begin
                            state_d = ISSUE_F;
                        end
                    end else begin
                        state_d = WAIT_D;
                        cnt_d   = LAT;
                    end
                end else if (mem_fetch) begin
                    ram_en_c = 1'b1;
                    ram_addr = fetch_word;
                    faddr_d  = fetch_word;
                    lane_d   = fetch_lane;
                    state_d  = WAIT_F;
                    cnt_d    = LAT;
                end
            end

            WAIT_D: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = ram_rdata;
                    state_d = pend_q ? ISSUE_F : IDLE;
                end
            end

            ISSUE_F: begin
                ram_en_c = 1'b1;
                ram_addr = faddr_q;
                pend_d   = 1'b0;
                state_d  = WAIT_F;
                cnt_d    = LAT;
            end

            WAIT_F: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    instr_d = sel_lane(ram_rdata, lane_q);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            faddr_q <= '0;
            lane_q  <= 2'd0;
            rdata_q <= 32'd0;
            instr_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            faddr_q <= faddr_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
        end
    end

    // The RAM strobes are forced off while reset is held, even though IDLE drives them combinationally.
    assign ram_en       = ram_en_c & resetn;
    assign ram_we       = ram_we_c & resetn;
    assign protocol_err = perr_c & resetn;
    assign stall        = (state_q != IDLE);
    assign mem_rdata    = rdata_q;
    assign mem_rd_instr = instr_q;

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed bench for mic1_mem_arbiter: two instances (RD_LATENCY 1 and 2) share the
// request stimulus, each with its own synchronous-read RAM model.
module tb_mic1_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr, mem_wdata, mem_addr_instr;
    logic        mem_read, mem_write, mem_fetch;

    logic [31:0] mem_rdata0, mem_rdata1;
    logic [7:0]  instr0, instr1;
    logic        stall0, stall1, perr0, perr1;
    logic        ram_en0, ram_en1, ram_we0, ram_we1;
    logic [15:0] ram_addr0, ram_addr1;
    logic [31:0] ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

    int checks = 0;
    int failures = 0;

    mic1_mem_arbiter #(.ADDR_W(16), .RD_LATENCY(1)) u0 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
        .mem_addr_instr(mem_addr_instr), .mem_rdata(mem_rdata0), .mem_rd_instr(instr0),
        .stall(stall0), .protocol_err(perr0), .ram_en(ram_en0), .ram_we(ram_we0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    mic1_mem_arbiter #(.ADDR_W(16), .RD_LATENCY(2)) u1 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
        .mem_addr_instr(mem_addr_instr), .mem_rdata(mem_rdata1), .mem_rd_instr(instr1),
        .stall(stall1), .protocol_err(perr1), .ram_en(ram_en1), .ram_we(ram_we1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: latency 1 (one output register) and latency 2 (two stages)
    logic [31:0] mem0 [0:65535];
    logic [31:0] mem1 [0:65535];
    logic [31:0] r0, s1a, s1b;

    always @(posedge clk) begin
        if (ram_en0) begin
            if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
            else         r0 <= mem0[ram_addr0];
        end
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
            else         s1a <= mem1[ram_addr1];
        end
        s1b <= s1a;
    end
    assign ram_rdata0 = r0;
    assign ram_rdata1 = s1b;

    // Observations from the last do_req
    int          st0, st1, we_cnt0;
    logic [31:0] cap_rd0, cap_rd1;
    logic [7:0]  cap_in0, cap_in1;
    logic        req_perr0, req_perr1, after_perr0;
    logic [15:0] req_addr0;
    logic [15:0] acc1 [0:3];
    int          acc_n;

    task automatic do_req(input logic rd, input logic wr, input logic f,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ai);
        bit seen0, seen1;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_fetch = f;
        mem_addr = a; mem_wdata = wd; mem_addr_instr = ai;
        @(negedge clk);
        req_perr0 = perr0; req_perr1 = perr1; req_addr0 = ram_addr0;
        we_cnt0 = ram_we0 ? 1 : 0;
        acc_n = 0;
        if (ram_en1) begin acc1[acc_n] = ram_addr1; acc_n++; end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; mem_fetch = 0;
        st0 = 0; st1 = 0; seen0 = 0; seen1 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) after_perr0 = perr0;
            if (ram_we0) we_cnt0++;
            if (ram_en1 && acc_n < 4) begin acc1[acc_n] = ram_addr1; acc_n++; end
            if (stall0) st0++;
            else if (!seen0) begin seen0 = 1; cap_rd0 = mem_rdata0; cap_in0 = instr0; end
            if (stall1) st1++;
            else if (!seen1) begin seen1 = 1; cap_rd1 = mem_rdata1; cap_in1 = instr1; end
        end
    endtask

    task automatic test_reset;
        resetn = 0;
        mem_read = 0; mem_write = 1; mem_fetch = 1;
        mem_addr = 32'h7; mem_wdata = 32'h1; mem_addr_instr = 32'h0;
        #23;
        checks++; if (ram_en0 !== 1'b0 || ram_we0 !== 1'b0) begin failures++;
            $display("FAIL reset_ram_strobe: en=%b we=%b required 0 0", ram_en0, ram_we0); end
        checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin failures++;
            $display("FAIL reset_stall: %b %b required 0 0", stall0, stall1); end
        checks++; if (mem_rdata0 !== 32'd0 || instr0 !== 8'd0 || perr0 !== 1'b0) begin failures++;
            $display("FAIL reset_outputs: rdata=%h instr=%h perr=%b required 0", mem_rdata0, instr0, perr0); end
        mem_write = 0; mem_fetch = 0;
        @(posedge clk); #1;
        resetn = 1;
    endtask

    task automatic test_write;
        do_req(0, 1, 0, 32'h20, 32'h12345678, 0);
        checks++; if (st0 !== 0 || st1 !== 0) begin failures++;
            $display("FAIL write_stall: %0d %0d required 0 0", st0, st1); end
        checks++; if (we_cnt0 !== 1) begin failures++;
            $display("FAIL write_we_pulses: %0d required 1", we_cnt0); end
        do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 1, 0, 32'h3, 32'hA1B2C3D4, 0);
        do_req(0, 1, 0, 32'h4, 32'h11223344, 0);
        do_req(0, 1, 0, 32'hFFFF, 32'h000000AB, 0);
        do_req(0, 1, 0, 32'h10005, 32'hCAFEF00D, 0);
        checks++; if (req_addr0 !== 16'h0005) begin failures++;
            $display("FAIL alias_addr: ram_addr=%h required 0005", req_addr0); end
    endtask

    task automatic test_read;
        do_req(1, 0, 0, 32'h10, 0, 0);
        checks++; if (st0 !== 1 || st1 !== 2) begin failures++;
            $display("FAIL read_stall: %0d %0d required 1 2", st0, st1); end
        checks++; if (cap_rd0 !== 32'hDEADBEEF || cap_rd1 !== 32'hDEADBEEF) begin failures++;
            $display("FAIL read_data: %h %h required deadbeef", cap_rd0, cap_rd1); end
        do_req(1, 0, 0, 32'h20, 0, 0);
        checks++; if (cap_rd0 !== 32'h12345678 || cap_rd1 !== 32'h12345678) begin failures++;
            $display("FAIL readback: %h %h required 12345678", cap_rd0, cap_rd1); end
    endtask

    task automatic test_read_fetch;
        do_req(1, 0, 1, 32'h3, 0, 32'h11);
        checks++; if (st0 !== 3 || st1 !== 5) begin failures++;
            $display("FAIL rf_stall: %0d %0d required 3 5", st0, st1); end
        checks++; if (cap_rd0 !== 32'hA1B2C3D4 || cap_rd1 !== 32'hA1B2C3D4) begin failures++;
            $display("FAIL rf_data: %h %h required a1b2c3d4", cap_rd0, cap_rd1); end
        checks++; if (cap_in0 !== 8'h22 || cap_in1 !== 8'h22) begin failures++;
            $display("FAIL rf_instr: %h %h required 22", cap_in0, cap_in1); end
        checks++; if (acc_n !== 2 || acc1[0] !== 16'h3 || acc1[1] !== 16'h4) begin failures++;
            $display("FAIL rf_order: n=%0d first=%h second=%h required 2 0003 0004", acc_n, acc1[0], acc1[1]); end
    endtask

    task automatic test_lane_wrap;
        do_req(0, 0, 1, 0, 0, 32'hFFFFFFFF);
        checks++; if (st0 !== 1 || st1 !== 2) begin failures++;
            $display("FAIL fetch_stall: %0d %0d required 1 2", st0, st1); end
        checks++; if (cap_in0 !== 8'hAB || cap_in1 !== 8'hAB) begin failures++;
            $display("FAIL wrap_instr: %h %h required ab", cap_in0, cap_in1); end
        do_req(1, 0, 0, 32'h5, 0, 0);
        checks++; if (cap_rd0 !== 32'hCAFEF00D || cap_rd1 !== 32'hCAFEF00D) begin failures++;
            $display("FAIL alias_read: %h %h required cafef00d", cap_rd0, cap_rd1); end
        checks++; if (cap_in0 !== 8'hAB) begin failures++;
            $display("FAIL instr_hold: %h required ab", cap_in0); end
    endtask

    task automatic test_write_fetch;
        do_req(0, 1, 1, 32'h30, 32'h55, 32'h12);
        checks++; if (st0 !== 2 || st1 !== 3) begin failures++;
            $display("FAIL wf_stall: %0d %0d required 2 3", st0, st1); end
        checks++; if (cap_in0 !== 8'h33 || cap_in1 !== 8'h33) begin failures++;
            $display("FAIL wf_instr: %h %h required 33", cap_in0, cap_in1); end
        checks++; if (we_cnt0 !== 1) begin failures++;
            $display("FAIL wf_we_pulses: %0d required 1", we_cnt0); end
    endtask

    task automatic test_rw_conflict;
        do_req(1, 1, 0, 32'h40, 32'h77777777, 0);
        checks++; if (req_perr0 !== 1'b1 || req_perr1 !== 1'b1) begin failures++;
            $display("FAIL perr_pulse: %b %b required 1 1", req_perr0, req_perr1); end
        checks++; if (after_perr0 !== 1'b0) begin failures++;
            $display("FAIL perr_width: %b required 0", after_perr0); end
        checks++; if (st0 !== 0 || st1 !== 0) begin failures++;
            $display("FAIL rw_stall: %0d %0d required 0 0", st0, st1); end
        checks++; if (cap_rd0 !== 32'hCAFEF00D || cap_rd1 !== 32'hCAFEF00D) begin failures++;
            $display("FAIL rw_rdata_held: %h %h required cafef00d", cap_rd0, cap_rd1); end
        do_req(1, 0, 0, 32'h40, 0, 0);
        checks++; if (cap_rd0 !== 32'h77777777 || cap_rd1 !== 32'h77777777) begin failures++;
            $display("FAIL rw_write_landed: %h %h required 77777777", cap_rd0, cap_rd1); end
        checks++; if (req_perr0 !== 1'b0) begin failures++;
            $display("FAIL perr_spurious: %b required 0", req_perr0); end
    endtask

    task automatic test_reset_mid;
        int en_cnt, st_cnt;
        @(posedge clk); #1;
        mem_read = 1; mem_fetch = 1; mem_addr = 32'h10; mem_addr_instr = 32'h11;
        @(posedge clk); #1;
        mem_read = 0; mem_fetch = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (stall1 !== 1'b1) begin failures++;
            $display("FAIL mid_precondition: stall=%b required 1", stall1); end
        resetn = 0;
        #1;
        checks++; if (stall1 !== 1'b0 || ram_en1 !== 1'b0) begin failures++;
            $display("FAIL mid_reset_stall: stall=%b en=%b required 0 0", stall1, ram_en1); end
        checks++; if (mem_rdata1 !== 32'd0 || instr1 !== 8'd0) begin failures++;
            $display("FAIL mid_reset_outputs: %h %h required 0 0", mem_rdata1, instr1); end
        @(posedge clk); #1;
        resetn = 1;
        en_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ram_en1) en_cnt++;
            if (stall1) st_cnt++;
        end
        checks++; if (en_cnt !== 0 || st_cnt !== 0) begin failures++;
            $display("FAIL mid_no_pending: accesses=%0d stalls=%0d required 0 0", en_cnt, st_cnt); end
        checks++; if (instr1 !== 8'd0) begin failures++;
            $display("FAIL mid_instr_after: %h required 0", instr1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_fetch();
        test_lane_wrap();
        test_write_fetch();
        test_rw_conflict();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
